// File: rtl/aes_scan_seq_pkg.sv
// Shared types and constants for the AES scan-chain sequencer.
package aes_scan_pkg;

    localparam int unsigned SI_LEN = 260;
    localparam int unsigned SO_LEN = 132;
    localparam int unsigned BCNT_W = 9;

    typedef enum logic [3:0] {
        IDLE, SI_SHIFT, SI_UPD, KEY, KWAIT, DATA, DWAIT, SO_CAP, SO_SHIFT, DONE
    } state_e;

    // Scanin stream; u[0] is the first bit shifted out.
    typedef struct packed {
        logic [127:0] key;
        logic [127:0] din;
        logic [3:0]   u;
    } si_word_t;

    // Scanout capture; sample k lands in bit k.
    typedef struct packed {
        logic [127:0] dout;
        logic [3:0]   u;
    } so_word_t;

    function automatic logic is_scan_state(input state_e s);
        return (s == SI_SHIFT) || (s == SI_UPD) || (s == SO_CAP) || (s == SO_SHIFT);
    endfunction

endpackage

// File: rtl/scan_clk_gen.sv
// Scan clock divider: toggles every SCLK_HALF cycles while running, with
// strobes asserted in the CLK cycle before scan_clk rises or falls.
module scan_clk_gen #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic restart_i,
    output logic scan_clk_o,
    output logic rise_pulse_c_o,
    output logic fall_pulse_c_o
);

    localparam int unsigned CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [CW-1:0] TC = CW'(SCLK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    // Stopped or freshly restarted dividers always start from a low phase.
    always_comb begin
        tc     = run_i && (cnt_q == TC);
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (restart_i || !run_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign scan_clk_o     = sclk_q;
    assign rise_pulse_c_o = tc && !sclk_q;
    assign fall_pulse_c_o = tc && sclk_q;

endmodule

// File: rtl/aes_scan_seq.sv
// Sequencer: serialises a host request into the scanin chain, runs AES_Comp,
// and deserialises the scanout chain back to the host.
module aes_scan_seq
    import aes_scan_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_vld,
    output logic         req_rdy,
    input  logic [127:0] req_key,
    input  logic [127:0] req_din,
    input  logic [3:0]   req_u,
    input  logic         req_key_reuse,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [127:0] res_dout,
    output logic [3:0]   res_u,
    output logic         res_err,
    output logic         scan_clk,
    output logic         scanin_in,
    output logic         scanin_se,
    output logic         scanin_update,
    output logic         scanout_se,
    input  logic         scanout_out,
    output logic         aes_krdy,
    output logic         aes_drdy,
    output logic         aes_en,
    input  logic         aes_bsy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [BCNT_W-1:0] SI_CNT   = BCNT_W'(SI_LEN);
    localparam logic [BCNT_W-1:0] SO_CNT   = BCNT_W'(SO_LEN);

    state_e              state_q, state_d;
    logic [SI_LEN-1:0]   sr_q, sr_d;
    logic [SO_LEN-1:0]   res_q, res_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d, bcnt_lim;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                seen_q, seen_d, reuse_q, reuse_d;
    logic                req_rdy_q, req_rdy_d, res_vld_q, res_vld_d, res_err_q, res_err_d;
    logic                si_se_q, si_se_d, si_upd_q, si_upd_d, so_se_q, so_se_d;
    logic                krdy_q, krdy_d, drdy_q, drdy_d, en_q, en_d;
    logic                restart_c, rise_c, fall_c, sclk_run;
    si_word_t            load_w;
    so_word_t            so_w;

    assign sclk_run = is_scan_state(state_q);

    scan_clk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
        .clk_i          (CLK),
        .rst_i          (RST),
        .run_i          (sclk_run),
        .restart_i      (restart_c),
        .scan_clk_o     (scan_clk),
        .rise_pulse_c_o (rise_c),
        .fall_pulse_c_o (fall_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            res_q     <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            seen_q    <= 1'b0;
            reuse_q   <= 1'b0;
            req_rdy_q <= 1'b1;
            res_vld_q <= 1'b0;
            res_err_q <= 1'b0;
            si_se_q   <= 1'b0;
            si_upd_q  <= 1'b0;
            so_se_q   <= 1'b0;
            krdy_q    <= 1'b0;
            drdy_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            res_q     <= res_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            seen_q    <= seen_d;
            reuse_q   <= reuse_d;
            req_rdy_q <= req_rdy_d;
            res_vld_q <= res_vld_d;
            res_err_q <= res_err_d;
            si_se_q   <= si_se_d;
            si_upd_q  <= si_upd_d;
            so_se_q   <= so_se_d;
            krdy_q    <= krdy_d;
            drdy_q    <= drdy_d;
            en_q      <= en_d;
        end
    end

    assign load_w   = '{key: req_key, din: req_din, u: req_u};
    assign bcnt_lim = (state_q == SO_SHIFT) ? SO_CNT : SI_CNT;

    // Scan-state transitions all land on a falling-edge strobe, so outputs
    // change together with scan_clk falling.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        res_d     = res_q;
        bcnt_d    = bcnt_q;
        tmo_d     = tmo_q;
        seen_d    = seen_q;
        reuse_d   = reuse_q;
        req_rdy_d = req_rdy_q;
        res_vld_d = res_vld_q;
        res_err_d = res_err_q;
        si_se_d   = si_se_q;
        si_upd_d  = si_upd_q;
        so_se_d   = so_se_q;
        krdy_d    = 1'b0;
        drdy_d    = 1'b0;
        en_d      = en_q;

        if (rise_c && (bcnt_q != bcnt_lim)) bcnt_d = bcnt_q + BCNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (req_vld && req_rdy_q) begin
                    sr_d      = load_w;
                    reuse_d   = req_key_reuse;
                    req_rdy_d = 1'b0;
                    res_err_d = 1'b0;
                    si_se_d   = 1'b1;
                    state_d   = SI_SHIFT;
                end
            end
            SI_SHIFT: begin
                if (fall_c) begin
                    sr_d = sr_q >> 1;
                    if (bcnt_q == SI_CNT) begin
                        si_se_d  = 1'b0;
                        si_upd_d = 1'b1;
                        state_d  = SI_UPD;
                    end
                end
            end
            SI_UPD: begin
                if (fall_c && (bcnt_q != '0)) begin
                    si_upd_d = 1'b0;
                    en_d     = 1'b1;
                    if (reuse_q) begin
                        drdy_d  = 1'b1;
                        tmo_d   = '0;
                        seen_d  = 1'b0;
                        state_d = DATA;
                    end else begin
                        krdy_d  = 1'b1;
                        state_d = KEY;
                    end
                end
            end
            KEY: state_d = KWAIT;
            KWAIT: begin
                if (!aes_bsy) begin
                    drdy_d  = 1'b1;
                    tmo_d   = '0;
                    seen_d  = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tmo_d   = tmo_q + TW'(1);
                state_d = DWAIT;
            end
            // A core that never raises BSY is treated as already finished.
            DWAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (aes_bsy) seen_d = 1'b1;
                if (seen_q && !aes_bsy) begin
                    state_d = SO_CAP;
                end else if (tmo_q == TMO_LAST) begin
                    if (seen_q || aes_bsy) begin
                        res_err_d = 1'b1;
                        res_vld_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = SO_CAP;
                    end
                end
            end
            SO_CAP: begin
                if (fall_c && (bcnt_q != '0)) begin
                    so_se_d = 1'b1;
                    state_d = SO_SHIFT;
                end
            end
            SO_SHIFT: begin
                if (rise_c && (bcnt_q != SO_CNT)) res_d = {scanout_out, res_q[SO_LEN-1:1]};
                if (fall_c && (bcnt_q == SO_CNT)) begin
                    so_se_d   = 1'b0;
                    res_vld_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (res_rdy) begin
                    res_vld_d = 1'b0;
                    res_err_d = 1'b0;
                    en_d      = 1'b0;
                    req_rdy_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        restart_c = (state_d != state_q) && is_scan_state(state_d);
        if (restart_c) bcnt_d = '0;
    end

    assign so_w          = res_q;
    assign req_rdy       = req_rdy_q;
    assign res_vld       = res_vld_q;
    assign res_err       = res_err_q;
    assign res_dout      = so_w.dout;
    assign res_u         = so_w.u;
    assign scanin_in     = sr_q[0];
    assign scanin_se     = si_se_q;
    assign scanin_update = si_upd_q;
    assign scanout_se    = so_se_q;
    assign aes_krdy      = krdy_q;
    assign aes_drdy      = drdy_q;
    assign aes_en        = en_q;

endmodule

// File: tb/tb_aes_scan_seq.sv
// Bench for aes_scan_seq: behavioural scan chains and AES_Comp stub, with a
// result scoreboard filled at request time.
module tb_aes_scan_seq;

    localparam int unsigned SCLK_HALF = 2;
    localparam int unsigned TIMEOUT   = 1024;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] D0 = 128'hB9D1C48E348FE771FA464A77A178FB07;
    localparam logic [127:0] C0 = 128'h95F8847369A8573D76AF987AB30A5DE2;
    localparam logic [127:0] D1 = 128'hDCFEAD50D1D9FD08B386EFB08B142F74;
    localparam logic [127:0] C1 = 128'h85E5F163C857B0AC1162E07DD3432B66;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req_vld, req_rdy, req_key_reuse;
    logic [127:0] req_key, req_din;
    logic [3:0]   req_u;
    logic         res_vld, res_rdy, res_err;
    logic [127:0] res_dout;
    logic [3:0]   res_u;
    logic         scan_clk, scanin_in, scanin_se, scanin_update, scanout_se, scanout_out;
    logic         aes_krdy, aes_drdy, aes_en, aes_bsy;

    always #5 CLK = ~CLK;

    aes_scan_seq #(.SCLK_HALF(SCLK_HALF), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_key(req_key), .req_din(req_din),
        .req_u(req_u), .req_key_reuse(req_key_reuse),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_dout(res_dout), .res_u(res_u),
        .res_err(res_err),
        .scan_clk(scan_clk), .scanin_in(scanin_in), .scanin_se(scanin_se),
        .scanin_update(scanin_update), .scanout_se(scanout_se), .scanout_out(scanout_out),
        .aes_krdy(aes_krdy), .aes_drdy(aes_drdy), .aes_en(aes_en), .aes_bsy(aes_bsy)
    );

    // Known vectors, otherwise a keyed surrogate.
    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] d);
        if (k == K0 && d == D0) return C0;
        if (k == K0 && d == D1) return C1;
        return d ^ {k[63:0], k[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    // Scan chain models and protocol counters.
    logic [259:0] si_sh  = '0;
    logic [259:0] si_par = '0;
    logic [131:0] so_sh  = '0;
    logic [127:0] core_key = '0, core_dout = '0;
    logic [3:0]   core_u = '0;
    logic         stuck_q = 1'b0;
    int unsigned  bcnt = 0, stub_mode = 0;
    int unsigned  n_si = 0, n_so = 0, n_cap = 0, n_upd = 0, n_krdy = 0, n_drdy = 0;
    int unsigned  cyc = 0, drdy_cyc = 0;

    assign scanout_out = so_sh[0];
    assign aes_bsy     = (stuck_q && stub_mode == 2) || (bcnt != 0);

    always @(posedge scan_clk) begin
        if (scanin_se) begin
            si_sh <= {scanin_in, si_sh[259:1]};
            n_si  <= n_si + 1;
        end
        if (scanout_se) begin
            so_sh <= so_sh >> 1;
            n_so  <= n_so + 1;
        end else begin
            so_sh <= {core_dout, core_u};
        end
        if (!scanin_se && !scanout_se && !scanin_update) n_cap <= n_cap + 1;
    end

    always @(posedge scanin_update) begin
        si_par <= si_sh;
        n_upd  <= n_upd + 1;
    end

    always @(negedge CLK) begin
        if (aes_krdy) n_krdy <= n_krdy + 1;
        if (aes_drdy) n_drdy <= n_drdy + 1;
    end

    // AES_Comp stub: mode 0 normal, 1 never busy, 2 busy stuck high.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (aes_drdy) drdy_cyc <= cyc;
        if (aes_en && aes_krdy) begin
            core_key <= si_par[259:132];
            bcnt     <= 4;
        end else if (aes_en && aes_drdy) begin
            core_dout <= aes_model(core_key, si_par[131:4]);
            core_u    <= si_par[3:0];
            stuck_q   <= (stub_mode == 2);
            bcnt      <= (stub_mode == 1) ? 0 : 12;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    typedef struct packed {
        logic [127:0] dout;
        logic [3:0]   u;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int unsigned  n_chk = 0, n_bad = 0;
    int unsigned  b_si, b_so, b_cap, b_upd, b_krdy, b_drdy, last_lat;
    logic [259:0] exp_stream;
    logic         exp_reuse;
    logic [127:0] model_key = '0;

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [127:0] k, input logic [127:0] d, input logic [3:0] u,
                            input logic reuse, input logic exp_err);
        exp_t        e;
        int unsigned w;
        w = 0;
        while (!req_rdy && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        chk("req_rdy_wait", 260'(req_rdy), 260'(1));
        b_si = n_si; b_so = n_so; b_cap = n_cap; b_upd = n_upd;
        b_krdy = n_krdy; b_drdy = n_drdy;
        req_key = k; req_din = d; req_u = u; req_key_reuse = reuse;
        req_vld = 1'b1;
        @(negedge CLK);
        req_vld = 1'b0;
        if (!reuse) model_key = k;
        e.dout = aes_model(model_key, d);
        e.u    = u;
        e.err  = exp_err;
        sb.push_back(e);
        exp_stream = {k, d, u};
        exp_reuse  = reuse;
    endtask

    task automatic get_res(input int unsigned hold, input logic proto);
        int unsigned  w;
        logic         stable;
        logic [127:0] d0;
        exp_t         e;
        w = 0;
        while (!res_vld && w < 20000) begin
            @(negedge CLK);
            w++;
        end
        chk("res_vld_wait", 260'(res_vld), 260'(1));
        e = sb.pop_front();
        if (!res_vld) return;
        last_lat = cyc - drdy_cyc;
        d0 = res_dout;
        stable = 1'b1;
        for (int i = 0; i < int'(hold); i++) begin
            req_vld = 1'b1;
            @(negedge CLK);
            if (res_dout !== d0 || !res_vld || req_rdy || scanin_se) stable = 1'b0;
        end
        req_vld = 1'b0;
        if (hold > 0) chk("hold_stable", 260'(stable), 260'(1));
        chk("res_err", 260'(res_err), 260'(e.err));
        if (!e.err) begin
            chk("res_dout", 260'(res_dout), 260'(e.dout));
            chk("res_u", 260'(res_u), 260'(e.u));
        end
        if (proto) begin
            chk("si_rises", 260'(n_si - b_si), 260'(260));
            chk("si_stream", si_par, exp_stream);
            chk("upd_pulses", 260'(n_upd - b_upd), 260'(1));
            chk("cap_edges", 260'(n_cap - b_cap), 260'(1));
            chk("so_rises", 260'(n_so - b_so), 260'(132));
            chk("krdy_cycles", 260'(n_krdy - b_krdy), exp_reuse ? 260'(0) : 260'(1));
            chk("drdy_cycles", 260'(n_drdy - b_drdy), 260'(1));
        end
        res_rdy = 1'b1;
        @(negedge CLK);
        res_rdy = 1'b0;
        chk("res_vld_clr", 260'(res_vld), 260'(0));
        chk("req_rdy_set", 260'(req_rdy), 260'(1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        RST = 1'b1; req_vld = 1'b0; req_key = '0; req_din = '0; req_u = '0;
        req_key_reuse = 1'b0; res_rdy = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_req_rdy", 260'(req_rdy), 260'(1));
        chk("rst_res", 260'({res_vld, res_err, res_dout, res_u}), 260'(0));
        chk("rst_scan", 260'({scan_clk, scanin_in, scanin_se, scanin_update, scanout_se}), 260'(0));
        chk("rst_aes", 260'({aes_krdy, aes_drdy, aes_en}), 260'(0));

        send_req(K0, D0, 4'h5, 1'b0, 1'b0);
        get_res(0, 1'b1);

        // Back-to-back with key reuse; the key on the bus must not be loaded.
        send_req(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, D1, 4'hA, 1'b1, 1'b0);
        get_res(0, 1'b1);

        send_req({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 4'h3, 1'b0, 1'b0);
        get_res(50, 1'b1);

        stub_mode = 1;
        send_req({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 4'h9, 1'b0, 1'b0);
        get_res(0, 1'b1);

        stub_mode = 2;
        send_req(128'h0, {$urandom, $urandom, $urandom, $urandom}, 4'h6, 1'b1, 1'b1);
        get_res(0, 1'b0);
        chk("tmo_latency", 260'(last_lat), 260'(TIMEOUT));
        chk("tmo_no_shift", 260'(n_so - b_so), 260'(0));
        stub_mode = 0;

        // Abort in the middle of the scanin shift.
        send_req({$urandom, $urandom, $urandom, $urandom}, D1, 4'hF, 1'b0, 1'b0);
        w = 0;
        while ((n_si - b_si) < 100 && w < 5000) begin
            @(negedge CLK);
            w++;
        end
        chk("mid_shift_reach", 260'(n_si - b_si), 260'(100));
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_req_rdy", 260'(req_rdy), 260'(1));
        chk("abort_scan", 260'({scan_clk, scanin_se, scanin_update, scanout_se}), 260'(0));
        chk("abort_aes", 260'({aes_krdy, aes_drdy, aes_en, res_vld}), 260'(0));
        RST = 1'b0;
        void'(sb.pop_back());
        @(negedge CLK);

        send_req(K0, D0, 4'hC, 1'b0, 1'b0);
        get_res(0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
